// File: rtl/tri_side_isqrt.sv
// Sequential integer square root of three squared side norms, one result bit
// per cycle (restoring digit-by-digit method), valid/ready on both sides.
module tri_side_isqrt #(
    parameter int DW = 17,
    localparam int RW = (DW + 1) / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] sq_ab,
    input  logic [DW-1:0] sq_bc,
    input  logic [DW-1:0] sq_ca,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] side_ab,
    output logic [RW-1:0] side_bc,
    output logic [RW-1:0] side_ca,
    output logic [2:0]    exact
);

    localparam int IW = $clog2(RW);
    localparam int XW = 2 * RW;
    localparam int EW = RW + 2;
    localparam logic [IW-1:0] I_TOP = IW'(RW - 1);
    localparam logic [IW-1:0] I_ZERO = IW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [XW-1:0]   x_ab_r;
    logic [XW-1:0]   x_bc_r;
    logic [XW-1:0]   x_ca_r;
    logic [1:0]      s_r;
    logic [IW-1:0]   i_r;
    logic [EW-1:0]   rem_r;
    logic [RW-1:0]   root_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [RW-1:0]   side_ab_r;
    logic [RW-1:0]   side_bc_r;
    logic [RW-1:0]   side_ca_r;
    logic [2:0]      exact_r;

    logic [XW-1:0]   x_sel_s;
    logic [EW-1:0]   rem_sh_s;
    logic [EW-1:0]   trial_s;
    logic [EW-1:0]   rem_step_s;
    logic [RW-1:0]   root_step_s;
    logic            last_bit_s;
    logic            last_side_s;
    logic            rem_zero_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign side_ab   = side_ab_r;
    assign side_bc   = side_bc_r;
    assign side_ca   = side_ca_r;
    assign exact     = exact_r;

    // Digit step on the selected radicand and FSM next-state decode.
    always_comb begin
        state_s     = state_r;
        x_sel_s     = x_ab_r;
        rem_step_s  = {EW{1'b0}};
        root_step_s = {RW{1'b0}};
        case (s_r)
            2'd0:    x_sel_s = x_ab_r;
            2'd1:    x_sel_s = x_bc_r;
            2'd2:    x_sel_s = x_ca_r;
            default: x_sel_s = x_ab_r;
        endcase
        // rem never exceeds 2*root, so dropping its two top bits loses nothing.
        rem_sh_s = {rem_r[EW-3:0], x_sel_s[{i_r, 1'b0} +: 2]};
        trial_s  = {root_r, 2'b01};
        if (rem_sh_s >= trial_s) begin
            rem_step_s  = rem_sh_s - trial_s;
            root_step_s = {root_r[RW-2:0], 1'b1};
        end else begin
            rem_step_s  = rem_sh_s;
            root_step_s = {root_r[RW-2:0], 1'b0};
        end
        rem_zero_s  = (rem_step_s == {EW{1'b0}});
        last_bit_s  = (i_r == I_ZERO);
        last_side_s = (s_r == 2'd2);
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_bit_s && last_side_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, handshake flags and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_ab_r      <= {XW{1'b0}};
            x_bc_r      <= {XW{1'b0}};
            x_ca_r      <= {XW{1'b0}};
            s_r         <= 2'd0;
            i_r         <= I_ZERO;
            rem_r       <= {EW{1'b0}};
            root_r      <= {RW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            side_ab_r   <= {RW{1'b0}};
            side_bc_r   <= {RW{1'b0}};
            side_ca_r   <= {RW{1'b0}};
            exact_r     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        x_ab_r     <= {{(XW-DW){1'b0}}, sq_ab};
                        x_bc_r     <= {{(XW-DW){1'b0}}, sq_bc};
                        x_ca_r     <= {{(XW-DW){1'b0}}, sq_ca};
                        s_r        <= 2'd0;
                        i_r        <= I_TOP;
                        rem_r      <= {EW{1'b0}};
                        root_r     <= {RW{1'b0}};
                        in_ready_r <= 1'b0;
                    end
                end
                CALC: begin
                    if (last_bit_s) begin
                        case (s_r)
                            2'd0: begin
                                side_ab_r  <= root_step_s;
                                exact_r[0] <= rem_zero_s;
                            end
                            2'd1: begin
                                side_bc_r  <= root_step_s;
                                exact_r[1] <= rem_zero_s;
                            end
                            2'd2: begin
                                side_ca_r  <= root_step_s;
                                exact_r[2] <= rem_zero_s;
                            end
                            default: begin
                                side_ab_r <= side_ab_r;
                            end
                        endcase
                        rem_r  <= {EW{1'b0}};
                        root_r <= {RW{1'b0}};
                        i_r    <= I_TOP;
                        s_r    <= s_r + 2'd1;
                        if (last_side_s) begin
                            out_valid_r <= 1'b1;
                        end
                    end else begin
                        rem_r  <= rem_step_s;
                        root_r <= root_step_s;
                        i_r    <= i_r - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule
